// File: rtl/dmem_responder.sv
// Data-memory responder: one word load/store at a time over req/ack with a fixed
// access latency, an error check on alignment/range, and a pipeline stall request.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];

  logic          resp_entry_s;
  logic          acc_we_s;
  logic          acc_err_s;
  logic          mem_wr_s;
  logic [31:0]   acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic [AW-1:0] acc_idx_s;

  // With LATENCY==1 RESP is entered straight from IDLE, so the access comes from the ports.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we_s    = we_i;
      acc_addr_s  = addr_i;
      acc_wdata_s = wdata_i;
    end else begin
      acc_we_s    = we_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
    acc_err_s = (acc_addr_s[1:0] != 2'b00) ||
                ({2'b00, acc_addr_s[31:2]} >= 32'(DEPTH));
    acc_idx_s = acc_addr_s[AW+1:2];
  end

  // Next-state, latched request and registered response values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdata_d      = 32'd0;
    resp_entry_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d      = RESP;
            resp_entry_s = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d      = RESP;
          resp_entry_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (resp_entry_s) begin
      ack_d = 1'b1;
      err_d = acc_err_s;
      if (!acc_we_s && !acc_err_s) begin
        rdata_d = mem[acc_idx_s];
      end else begin
        rdata_d = 32'd0;
      end
    end else begin
      ack_d = 1'b0;
    end
  end

  // Reset gates the write so an in-flight store can never commit while rst_i is high.
  assign mem_wr_s = resp_entry_s & acc_we_s & ~acc_err_s & ~rst_i;

  // Array write port; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_wr_s) begin
      mem[acc_idx_s] <= acc_wdata_s;
    end
  end

  // State, latched request and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign stall_o = ((state_q != IDLE) | req_i) & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder with LATENCY=3 and LATENCY=1 instances.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req3 = 1'b0, we3 = 1'b0, ack3, err3, stall3;
  logic [31:0] addr3 = 32'd0, wd3 = 32'd0, rd3;
  logic        req1 = 1'b0, we1 = 1'b0, ack1, err1, stall1;
  logic [31:0] addr1 = 32'd0, wd1 = 32'd0, rd1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [2][16];

  dmem_responder #(.DEPTH(256), .LATENCY(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we3), .addr_i(addr3), .wdata_i(wd3),
    .ack_o(ack3), .rdata_o(rd3), .err_o(err3), .stall_o(stall3));

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wd1),
    .ack_o(ack1), .rdata_o(rd1), .err_o(err1), .stall_o(stall1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rq, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req3 = rq; we3 = we; addr3 = a; wd3 = d;
    end else begin
      req1 = rq; we1 = we; addr1 = a; wd1 = d;
    end
  endtask

  task automatic sample(input int sel, output logic ack, output logic err,
                        output logic [31:0] rd, output logic stall);
    if (sel == 0) begin
      ack = ack3; err = err3; rd = rd3; stall = stall3;
    end else begin
      ack = ack1; err = err1; rd = rd1; stall = stall1;
    end
  endtask

  // One complete access: request in cycle 0, ack expected exactly LATENCY cycles later.
  task automatic access(input int sel, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_rd, input bit drop, input string tag);
    logic ack, err, stall;
    logic [31:0] rd;
    int lat;
    lat = (sel == 0) ? 3 : 1;
    @(negedge clk);
    drive(sel, 1'b1, we, a, d);
    #1;
    sample(sel, ack, err, rd, stall);
    chk({tag, ".stall0"}, {31'd0, stall}, 32'd1);
    chk({tag, ".ack0"}, {31'd0, ack}, 32'd0);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (drop && n == 1) drive(sel, 1'b0, we, a, d);
      #1;
      sample(sel, ack, err, rd, stall);
      if (n < lat) begin
        chk({tag, ".ack_early"}, {31'd0, ack}, 32'd0);
        chk({tag, ".stall_busy"}, {31'd0, stall}, 32'd1);
      end else begin
        chk({tag, ".ack"}, {31'd0, ack}, 32'd1);
        chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, ".stall_ack"}, {31'd0, stall}, 32'd0);
        if (!we) chk({tag, ".rdata"}, rd, exp_rd);
      end
    end
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    sample(sel, ack, err, rd, stall);
    chk({tag, ".ack_after"}, {31'd0, ack}, 32'd0);
    chk({tag, ".err_after"}, {31'd0, err}, 32'd0);
    chk({tag, ".rd_after"}, rd, 32'd0);
    chk({tag, ".idle_after"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [31:0] seq_addr [6];
    logic [31:0] seq_data [6];
    logic        seq_we   [6];

    // Reset state
    #12;
    chk("rst.ack3", {31'd0, ack3}, 32'd0);
    chk("rst.err3", {31'd0, err3}, 32'd0);
    chk("rst.rd3", rd3, 32'd0);
    chk("rst.stall3", {31'd0, stall3}, 32'd0);
    chk("rst.ack1", {31'd0, ack1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1. LATENCY=3 store then load
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, "t1.st");
    access(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0, "t1.ld");

    // 2. LATENCY=1 back-to-back store/load with req held high
    seq_addr = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h3FC, 32'h3FC};
    seq_data = '{32'h1, 32'h0, 32'h2, 32'h0, 32'h3, 32'h0};
    seq_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive(1, 1'b1, seq_we[0], seq_addr[0], seq_data[0]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("t2.ack", {31'd0, ack1}, 32'd1);
      chk("t2.err", {31'd0, err1}, 32'd0);
      if (!seq_we[k]) chk("t2.rdata", rd1, seq_data[k-1]);
      if (k < 5) drive(1, 1'b1, seq_we[k+1], seq_addr[k+1], seq_data[k+1]);
      else       drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      #1;
      chk("t2.gap_ack", {31'd0, ack1}, 32'd0);
      chk("t2.gap_stall", {31'd0, stall1}, (k < 5) ? 32'd1 : 32'd0);
    end

    // 3. Error accesses leave the array untouched
    access(1, 1'b0, 32'h2, 32'd0, 1'b1, 32'd0, 1'b0, "t3.ld_mis");
    access(1, 1'b1, 32'h400, 32'hBAD0BAD0, 1'b1, 32'd0, 1'b0, "t3.st_oor");
    access(1, 1'b1, 32'h3FE, 32'hBAD1BAD1, 1'b1, 32'd0, 1'b0, "t3.st_mis");
    access(1, 1'b0, 32'h401, 32'd0, 1'b1, 32'd0, 1'b0, "t3.ld_both");
    access(1, 1'b0, 32'h0, 32'd0, 1'b0, 32'h1, 1'b0, "t3.rb0");
    access(1, 1'b0, 32'h3FC, 32'd0, 1'b0, 32'h3, 1'b0, "t3.rb3fc");
    access(0, 1'b0, 32'h3FC, 32'd0, 1'b0, 32'd0, 1'b0, "t3.ld3fc_l3");

    // 4. req drop during BUSY does not cancel
    access(0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'd0, 1'b1, "t4.st_drop");
    access(0, 1'b0, 32'h30, 32'd0, 1'b0, 32'hCAFEF00D, 1'b1, "t4.ld_drop");

    // 5. Reset during BUSY discards the store; reset during RESP keeps it
    access(0, 1'b1, 32'h20, 32'h11, 1'b0, 32'd0, 1'b0, "t5.pre");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h55);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5.rst_ack", {31'd0, ack3}, 32'd0);
    chk("t5.rst_rd", rd3, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t5.no_ack", {31'd0, ack3}, 32'd0);
    end
    rst = 1'b0;
    access(0, 1'b0, 32'h20, 32'd0, 1'b0, 32'h11, 1'b0, "t5.ld20");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h24, 32'h77);
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t5.resp_ack", {31'd0, ack3}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5.async_ack", {31'd0, ack3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    access(0, 1'b0, 32'h24, 32'd0, 1'b0, 32'h77, 1'b0, "t5.ld24");

    // 6. Random stress against a reference model
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        mdl[s][i] = 32'hA5000000 + 32'(i) + 32'(s * 256);
        access(s, 1'b1, 32'h100 + 32'(i * 4), mdl[s][i], 1'b0, 32'd0, 1'b0, "t6.pre");
      end
    end
    for (int it = 0; it < 60; it++) begin
      int sel, idx, gap, kind;
      logic we;
      logic [31:0] a, d;
      sel  = int'($urandom_range(1));
      idx  = int'($urandom_range(15));
      kind = int'($urandom_range(7));
      we   = 1'($urandom_range(1));
      d    = $urandom;
      gap  = int'($urandom_range(3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("t6.idle_ack3", {31'd0, ack3}, 32'd0);
        chk("t6.idle_ack1", {31'd0, ack1}, 32'd0);
      end
      if (kind == 0) begin
        a = 32'h400 + 32'(idx * 4);
        access(sel, we, a, d, 1'b1, 32'd0, 1'b0, "t6.oor");
      end else if (kind == 1) begin
        a = 32'h101 + 32'(idx * 4);
        access(sel, we, a, d, 1'b1, 32'd0, 1'b0, "t6.mis");
      end else begin
        a = 32'h100 + 32'(idx * 4);
        access(sel, we, a, d, 1'b0, mdl[sel][idx], 1'b0, "t6.ok");
        if (we) mdl[sel][idx] = d;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
